strobe_gen_multi: RTL and testbench

Parametrised multi-channel strobe generator, successor to the single-channel lamp strobe block. Each channel runs its own prescaled delay counter. It produces either one strobe, or a train of strobes repeated at a programmable period. It sits between the register file (FPGA_* config words) and the lamp driver outputs.

---
 rtl/strobe_gen_multi.sv | 132 +++++++++++++
 tb/tb_strobe_gen_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_gen_multi.sv
// strobe_gen_multi: NUM_CH independent prescaled single/train strobe generators; STROBE_RETRIGGER_EN enables single-mode retrigger.
// Latency: strobe_out registered one cycle after the cnt compare; no backpressure, triggers while busy are dropped unless retrigger applies.
module strobe_gen_multi #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 16,
   parameter int PRESCALE = 24
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [NUM_CH-1:0]         lamp_enable,
   input  logic [NUM_CH-1:0]         trigger,
   input  logic [NUM_CH-1:0]         mode,
   input  logic [NUM_CH*CNT_W-1:0]   high_delay,
   input  logic [NUM_CH*CNT_W-1:0]   low_delay,
   input  logic [NUM_CH*CNT_W-1:0]   period,
   input  logic [NUM_CH*CNT_W-1:0]   strobe_count,
   output logic [NUM_CH-1:0]         strobe_out,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done
);

   localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   typedef struct packed {
      logic             mode;
      logic [CNT_W-1:0] hd;
      logic [CNT_W-1:0] ld;
      logic [CNT_W-1:0] per;
      logic [CNT_W-1:0] num;
   } cfg_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state;
      logic [PRE_W-1:0] pre;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] pn;
      cfg_t             cfg;
      cfg_t             cfg_in;
      logic             strobe_q;
      logic             done_q;
      logic [CNT_W-1:0] end_cnt;
      logic [CNT_W-1:0] cnt_inc;
      logic [PRE_W-1:0] pre_inc;
      logic             strobe_nxt;
      logic             retrig;
      logic             launch;
      logic             last_pulse;

      always_comb begin
         cfg_in      = '0;
         cfg_in.mode = mode[i];
         cfg_in.hd   = high_delay[i*CNT_W +: CNT_W];
         cfg_in.ld   = low_delay[i*CNT_W +: CNT_W];
         cfg_in.per  = period[i*CNT_W +: CNT_W];
         cfg_in.num  = strobe_count[i*CNT_W +: CNT_W];

         // Train period is max(period, low_delay, 1) so the pulse always fits
         end_cnt = cfg.per;
         if (cfg.ld > end_cnt) end_cnt = cfg.ld;
         if (end_cnt == '0)    end_cnt = CNT_ONE;

         pre_inc = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
         cnt_inc = (pre == PRE_LAST && cnt != CNT_MAX) ? cnt + CNT_ONE : cnt;

         strobe_nxt = (state == ST_RUN) && (cfg.hd <= cnt) && (cnt < cfg.ld);
         last_pulse = (cfg.num != '0) && ((pn + CNT_ONE) == cfg.num);

`ifdef STROBE_RETRIGGER_EN
         retrig = (state == ST_RUN) && !cfg.mode;
`else
         retrig = 1'b0;
`endif
         launch = trigger[i] && ((state == ST_IDLE) || retrig);
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            state    <= ST_IDLE;
            pre      <= '0;
            cnt      <= '0;
            pn       <= '0;
            cfg      <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
         end else begin
            done_q   <= 1'b0;
            strobe_q <= strobe_nxt;
            if (!lamp_enable[i]) begin
               state    <= ST_IDLE;
               strobe_q <= 1'b0;
            end else if (launch) begin
               state <= ST_RUN;
               cfg   <= cfg_in;
               pre   <= '0;
               cnt   <= '0;
               pn    <= '0;
            end else if (state == ST_RUN) begin
               if (!cfg.mode) begin
                  if (cnt == cfg.ld) begin
                     state  <= ST_IDLE;
                     done_q <= 1'b1;
                  end else begin
                     pre <= pre_inc;
                     cnt <= cnt_inc;
                  end
               end else if (cnt == end_cnt) begin
                  pre <= '0;
                  cnt <= '0;
                  pn  <= pn + CNT_ONE;
                  if (last_pulse) begin
                     state  <= ST_IDLE;
                     done_q <= 1'b1;
                  end
               end else begin
                  pre <= pre_inc;
                  cnt <= cnt_inc;
               end
            end
         end
      end

      assign strobe_out[i] = strobe_q;
      assign busy[i]       = (state == ST_RUN);
      assign done[i]       = done_q;
   end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Directed bench for strobe_gen_multi: expected output edges are queued per scenario and matched as the DUT toggles.
module tb_strobe_gen_multi;
   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 16;
   localparam int PRESCALE = 24;

   logic                    sys_clk = 1'b0;
   logic                    sys_rst_n;
   logic [NUM_CH-1:0]       lamp_enable;
   logic [NUM_CH-1:0]       trigger;
   logic [NUM_CH-1:0]       mode;
   logic [NUM_CH*CNT_W-1:0] high_delay;
   logic [NUM_CH*CNT_W-1:0] low_delay;
   logic [NUM_CH*CNT_W-1:0] period;
   logic [NUM_CH*CNT_W-1:0] strobe_count;
   logic [NUM_CH-1:0]       strobe_out;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH-1:0]       done;

   int                total = 0;
   int                bad   = 0;
   int                cyc;
   int                exp_q[$];
   logic [NUM_CH-1:0] prev[3];

   always #5 sys_clk = ~sys_clk;

   strobe_gen_multi #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .PRESCALE(PRESCALE)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .lamp_enable (lamp_enable),
      .trigger     (trigger),
      .mode        (mode),
      .high_delay  (high_delay),
      .low_delay   (low_delay),
      .period      (period),
      .strobe_count(strobe_count),
      .strobe_out  (strobe_out),
      .busy        (busy),
      .done        (done)
   );

   // Edge key: cycle, signal (0 strobe, 1 busy, 2 done), channel, new level
   function automatic int ev_key(input int c, input int sig, input int ch, input int val);
      return ((c * 4 + sig) * 8 + ch) * 2 + val;
   endfunction

   function automatic logic [NUM_CH-1:0] sig_vec(input int s);
      case (s)
         0:       return strobe_out;
         1:       return busy;
         default: return done;
      endcase
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic exp_pulse(input int sig, input int ch, input int start, input int len);
      exp_q.push_back(ev_key(start, sig, ch, 1));
      exp_q.push_back(ev_key(start + len, sig, ch, 0));
   endtask

   task automatic set_ch(input int ch, input logic m, input int hd, input int ld,
                         input int per, input int num);
      mode[ch]                       = m;
      high_delay[ch*CNT_W +: CNT_W]   = CNT_W'(hd);
      low_delay[ch*CNT_W +: CNT_W]    = CNT_W'(ld);
      period[ch*CNT_W +: CNT_W]       = CNT_W'(per);
      strobe_count[ch*CNT_W +: CNT_W] = CNT_W'(num);
   endtask

   // Cycle c is observed at the falling edge inside it; inputs driven after
   // the observation are captured by the rising edge that closes cycle c.
   task automatic tick();
      logic [NUM_CH-1:0] cur;
      int                got;
      int                want;
      @(negedge sys_clk);
      cyc++;
      for (int s = 0; s < 3; s++) begin
         cur = sig_vec(s);
         for (int c = 0; c < NUM_CH; c++) begin
            if (cur[c] !== prev[s][c]) begin
               got  = ev_key(cyc, s, c, (cur[c] === 1'b1) ? 1 : 0);
               want = -1;
               if (exp_q.size() > 0) want = exp_q.pop_front();
               check($sformatf("edge cyc%0d sig%0d ch%0d", cyc, s, c), got, want);
            end
         end
         prev[s] = cur;
      end
   endtask

   task automatic run_to(input int last);
      while (cyc < last) tick();
   endtask

   task automatic start_test();
      exp_q.sort();
      cyc = -1;
      tick();
   endtask

   task automatic end_test(input string name);
      check({name, " unmatched"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      sys_rst_n    = 1'b1;
      lamp_enable  = '1;
      trigger      = '0;
      mode         = '0;
      high_delay   = '0;
      low_delay    = '0;
      period       = '0;
      strobe_count = '0;
      for (int s = 0; s < 3; s++) prev[s] = '0;
      cyc = 0;

      #2 sys_rst_n = 1'b0;
      #1;
      check("reset strobe_out", int'(strobe_out), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // Single strobe, hd=2 ld=5
      set_ch(0, 1'b0, 2, 5, 0, 0);
      exp_pulse(0, 0, 50, 72);
      exp_pulse(1, 0, 1, 121);
      exp_pulse(2, 0, 122, 1);
      start_test();
      trigger[0] = 1'b1;
      tick();
      trigger[0] = 1'b0;
      run_to(130);
      end_test("single");

      // Train of three; the wrap cycle at cnt==end makes each period 4*24+1 cycles
      set_ch(1, 1'b1, 0, 1, 4, 3);
      exp_pulse(0, 1, 2, 24);
      exp_pulse(0, 1, 99, 24);
      exp_pulse(0, 1, 196, 24);
      exp_pulse(1, 1, 1, 291);
      exp_pulse(2, 1, 292, 1);
      start_test();
      trigger[1] = 1'b1;
      tick();
      trigger[1] = 1'b0;
      run_to(300);
      end_test("train");

      // Endless train aborted mid-pulse by lamp_enable
      set_ch(2, 1'b1, 0, 2, 3, 0);
      exp_pulse(0, 2, 2, 29);
      exp_pulse(1, 2, 1, 30);
      start_test();
      trigger[2] = 1'b1;
      tick();
      trigger[2] = 1'b0;
      run_to(30);
      lamp_enable[2] = 1'b0;
      run_to(120);
      lamp_enable[2] = 1'b1;
      end_test("abort");

      // hd == ld: timing runs without a pulse
      set_ch(3, 1'b0, 5, 5, 0, 0);
      exp_pulse(1, 3, 1, 121);
      exp_pulse(2, 3, 122, 1);
      start_test();
      trigger[3] = 1'b1;
      tick();
      trigger[3] = 1'b0;
      run_to(130);
      end_test("nopulse");

      // All channels together, config rewritten while running
      set_ch(0, 1'b0, 1, 3, 0, 0);
      set_ch(1, 1'b0, 0, 2, 0, 0);
      set_ch(2, 1'b1, 1, 2, 3, 2);
      set_ch(3, 1'b1, 0, 3, 2, 1);
      exp_pulse(0, 0, 26, 48);
      exp_pulse(1, 0, 1, 73);
      exp_pulse(2, 0, 74, 1);
      exp_pulse(0, 1, 2, 48);
      exp_pulse(1, 1, 1, 49);
      exp_pulse(2, 1, 50, 1);
      exp_pulse(0, 2, 26, 24);
      exp_pulse(0, 2, 99, 24);
      exp_pulse(1, 2, 1, 146);
      exp_pulse(2, 2, 147, 1);
      exp_pulse(0, 3, 2, 72);
      exp_pulse(1, 3, 1, 73);
      exp_pulse(2, 3, 74, 1);
      start_test();
      trigger = '1;
      tick();
      trigger = '0;
      run_to(5);
      high_delay = '0;
      low_delay  = {NUM_CH{CNT_W'(9)}};
      mode       = ~mode;
      run_to(160);
      end_test("multi");

      // Trigger again while ch0 single run sits at cnt=3
      set_ch(0, 1'b0, 2, 5, 0, 0);
`ifdef STROBE_RETRIGGER_EN
      exp_pulse(0, 0, 50, 32);
      exp_pulse(0, 0, 130, 72);
      exp_pulse(1, 0, 1, 201);
      exp_pulse(2, 0, 202, 1);
`else
      exp_pulse(0, 0, 50, 72);
      exp_pulse(1, 0, 1, 121);
      exp_pulse(2, 0, 122, 1);
`endif
      start_test();
      trigger[0] = 1'b1;
      tick();
      trigger[0] = 1'b0;
      run_to(80);
      trigger[0] = 1'b1;
      tick();
      trigger[0] = 1'b0;
      run_to(210);
      end_test("retrigger");

      // Asynchronous reset while strobing
      set_ch(0, 1'b0, 0, 9, 0, 0);
      exp_pulse(1, 0, 1, 1000);
      exp_pulse(0, 0, 2, 1000);
      start_test();
      trigger[0] = 1'b1;
      tick();
      trigger[0] = 1'b0;
      run_to(40);
      check("pre-reset strobe_out", int'(strobe_out), 1);
      check("pre-reset busy", int'(busy), 1);
      exp_q.delete();
      #2 sys_rst_n = 1'b0;
      #1;
      check("async reset strobe_out", int'(strobe_out), 0);
      check("async reset busy", int'(busy), 0);
      check("async reset done", int'(done), 0);
      #1 sys_rst_n = 1'b1;
      for (int s = 0; s < 3; s++) prev[s] = sig_vec(s);
      run_to(60);
      end_test("post-reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
